// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with early pixel requests, configurable sync
// polarity, line/frame strobes and a colour-bar test pattern latched per frame.
module vga_timing_gen #(
   parameter int H_SYNC   = 120,
   parameter int H_BACK   = 64,
   parameter int H_ACTIVE = 800,
   parameter int H_FRONT  = 56,
   parameter int V_SYNC   = 6,
   parameter int V_BACK   = 23,
   parameter int V_ACTIVE = 600,
   parameter int V_FRONT  = 37,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1,
   parameter int RGB_W    = 3,
   parameter int PIX_LAT  = 1,
   parameter int CW       = 11
) (
   input  logic             vga_clk,
   input  logic             sys_rst,
   input  logic             pat_en,
   input  logic [RGB_W-1:0] pix_data,
   output logic             pix_req,
   output logic [CW-1:0]    pix_x,
   output logic [CW-1:0]    pix_y,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             frame_start,
   output logic             line_start,
   output logic             pat_active
);

   localparam int   H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int   V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int   HA_S    = H_SYNC + H_BACK;
   localparam int   VA_S    = V_SYNC + V_BACK;
   localparam int   BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam int   CC      = RGB_W / 3;
   localparam logic HS_ON   = (HS_POL != 0);
   localparam logic VS_ON   = (VS_POL != 0);

   // Each channel is all-ones when its bar-index bit is set; R sits in the MSBs.
   function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] b);
      return {{CC{b[2]}}, {CC{b[1]}}, {CC{b[0]}}};
   endfunction

   logic            r_run;
   logic [CW-1:0]   r_h;
   logic [CW-1:0]   r_v;
   logic            r_hsync;
   logic            r_vsync;
   logic            r_de;
   logic            r_req;
   logic [CW-1:0]   r_x;
   logic [CW-1:0]   r_y;
   logic            r_fs;
   logic            r_ls;
   logic [2:0]      r_bar;
   logic            r_pat_mode;

   logic            w_h_last;
   logic            w_v_last;
   logic            w_h_act;
   logic            w_v_act;
   logic            w_req;
   logic [CW:0]     w_hl;
   logic [CW-1:0]   w_x;
   logic [CW-1:0]   w_y;
   logic [2:0]      w_bar;

   always_comb begin
      w_h_last = (r_h == CW'(H_TOTAL - 1));
      w_v_last = (r_v == CW'(V_TOTAL - 1));
      w_h_act  = (r_h >= CW'(HA_S)) && (r_h < CW'(HA_S + H_ACTIVE));
      w_v_act  = (r_v >= CW'(VA_S)) && (r_v < CW'(VA_S + V_ACTIVE));
      // One extra bit so the look-ahead column never wraps before the compare.
      w_hl     = {1'b0, r_h} + (CW+1)'(PIX_LAT);
      w_req    = w_v_act && (w_hl >= (CW+1)'(HA_S)) && (w_hl < (CW+1)'(HA_S + H_ACTIVE));
      w_x      = r_h + CW'(PIX_LAT) - CW'(HA_S);
      w_y      = r_v - CW'(VA_S);
      w_bar    = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (r_h >= CW'(HA_S + k * BAR_W)) begin
            w_bar = 3'(k);
         end
      end
   end

   // r_run holds the counters for one edge after reset so the first strobes land
   // on the second edge.
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_run      <= 1'b0;
         r_h        <= '0;
         r_v        <= '0;
         r_hsync    <= ~HS_ON;
         r_vsync    <= ~VS_ON;
         r_de       <= 1'b0;
         r_req      <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_fs       <= 1'b0;
         r_ls       <= 1'b0;
         r_bar      <= 3'd0;
         r_pat_mode <= 1'b0;
      end else if (!r_run) begin
         r_run <= 1'b1;
      end else begin
         r_h <= w_h_last ? '0 : r_h + CW'(1);
         if (w_h_last) begin
            r_v <= w_v_last ? '0 : r_v + CW'(1);
         end
         if (w_h_last && w_v_last) begin
            r_pat_mode <= pat_en;
         end
         r_hsync <= (r_h < CW'(H_SYNC)) ? HS_ON : ~HS_ON;
         r_vsync <= (r_v < CW'(V_SYNC)) ? VS_ON : ~VS_ON;
         r_de    <= w_h_act && w_v_act;
         r_req   <= w_req;
         r_x     <= w_req ? w_x : '0;
         r_y     <= w_req ? w_y : '0;
         r_ls    <= (r_h == '0);
         r_fs    <= (r_h == '0) && (r_v == '0);
         r_bar   <= w_bar;
      end
   end

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign pix_req     = r_req;
   assign pix_x       = r_x;
   assign pix_y       = r_y;
   assign line_start  = r_ls;
   assign frame_start = r_fs;
   assign pat_active  = r_pat_mode;
   assign vga_rgb     = r_de ? (r_pat_mode ? bar_colour(r_bar) : pix_data) : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-timing instances (PIX_LAT 0/1/4, one with
// inverted sync polarity) plus one default-timing instance, all on a shared clock/reset.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst;
   logic pat_en;
   int   cyc;
   int   run_id;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   // Edge count since reset release: after edge k, cyc == k.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // ---------------- small-timing instances: H 2/2/8/2 (14), V 1/1/4/1 (7) ----------------
   logic        s_hs  [3];
   logic        s_vs  [3];
   logic        s_de  [3];
   logic        s_req [3];
   logic        s_fs  [3];
   logic        s_ls  [3];
   logic        s_pa  [3];
   logic [10:0] s_x   [3];
   logic [10:0] s_y   [3];
   logic [2:0]  s_rgb [3];

   for (genvar g = 0; g < 3; g++) begin : g_s
      localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 4;
      localparam int POL = (g == 2) ? 0 : 1;
      logic [2:0] enc;
      logic [2:0] dat;
      logic [2:0] pipe [1:4];
      assign enc = {s_x[g][0], s_y[g][0], 1'b1};
      always @(posedge clk) begin
         pipe[1] <= enc;
         for (int i = 2; i <= 4; i++) pipe[i] <= pipe[i-1];
      end
      if (LAT == 0) begin : g_l0
         assign dat = enc;
      end else begin : g_ln
         assign dat = pipe[LAT];
      end
      vga_timing_gen #(
         .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
         .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
         .HS_POL(POL), .VS_POL(POL), .RGB_W(3), .PIX_LAT(LAT), .CW(11)
      ) u_dut (
         .vga_clk(clk), .sys_rst(rst), .pat_en((g == 1) ? pat_en : 1'b0), .pix_data(dat),
         .pix_req(s_req[g]), .pix_x(s_x[g]), .pix_y(s_y[g]), .hsync(s_hs[g]),
         .vsync(s_vs[g]), .de(s_de[g]), .vga_rgb(s_rgb[g]), .frame_start(s_fs[g]),
         .line_start(s_ls[g]), .pat_active(s_pa[g])
      );
   end

   // ---------------- default-timing instance ----------------
   logic        d_hs, d_vs, d_de, d_req, d_fs, d_ls, d_pa;
   logic [10:0] d_x, d_y;
   logic [2:0]  d_rgb;

   vga_timing_gen u_def (
      .vga_clk(clk), .sys_rst(rst), .pat_en(1'b0), .pix_data(3'b000),
      .pix_req(d_req), .pix_x(d_x), .pix_y(d_y), .hsync(d_hs), .vsync(d_vs), .de(d_de),
      .vga_rgb(d_rgb), .frame_start(d_fs), .line_start(d_ls), .pat_active(d_pa)
   );

   // Expected small-instance outputs after edge k (state of edge k is (k-2) mod 98).
   function automatic logic [31:0] exp_small(input int k, input int lat, input logic pol,
                                             input logic pa);
      int p, h, v, x, y;
      logic hs, vs, de, req, fs, ls;
      logic [10:0] px, py;
      logic [2:0]  rgb;
      if (k < 2) return {~pol, ~pol, 30'd0};
      p   = (k - 2) % 98;
      h   = p % 14;
      v   = p / 14;
      x   = h - 4;
      y   = v - 2;
      hs  = (h < 2) ? pol : ~pol;
      vs  = (v < 1) ? pol : ~pol;
      de  = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
      req = (h + lat >= 4) && (h + lat < 12) && (v >= 2) && (v < 6);
      px  = req ? 11'(h + lat - 4) : 11'd0;
      py  = req ? 11'(y) : 11'd0;
      fs  = (p == 0);
      ls  = (h == 0);
      if (!de)     rgb = 3'd0;
      else if (pa) rgb = 3'(x);
      else         rgb = {x[0], y[0], 1'b1};
      return {hs, vs, de, req, fs, ls, pa, px, py, rgb};
   endfunction

   task automatic tick();
      int lat;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         lat = (g == 0) ? 0 : (g == 1) ? 1 : 4;
         chk($sformatf("small%0d_c%0d", g, cyc),
             {s_hs[g], s_vs[g], s_de[g], s_req[g], s_fs[g], s_ls[g], s_pa[g],
              s_x[g], s_y[g], s_rgb[g]},
             exp_small(cyc, lat, (g != 2),
                       (g == 1) && (run_id == 0) && (cyc >= 197) && (cyc < 295)));
      end
   endtask

   task automatic step_to(input int k);
      int guard;
      guard = 0;
      while (cyc < k && guard < 100000) begin
         tick();
         guard++;
      end
   endtask

   initial begin
      int last_ls, hs_cnt, vs_cnt, de_cnt, fs_n;
      bit de_seen;
      rst    = 1'b1;
      pat_en = 1'b0;
      run_id = 0;
      repeat (3) tick();
      chk("rst_hs_pos", 32'(s_hs[1]), 0);
      chk("rst_hs_neg", 32'(s_hs[2]), 1);
      chk("rst_vs_neg", 32'(s_vs[2]), 1);
      chk("rst_de", 32'(d_de), 0);
      chk("rst_rgb", 32'(s_rgb[1]), 0);
      #2 rst = 1'b0;

      step_to(1);
      chk("fs_edge1", 32'(s_fs[1]), 0);
      step_to(2);
      chk("fs_edge2", 32'(s_fs[1]), 1);
      chk("hs_edge2", 32'(s_hs[1]), 1);
      step_to(30);
      chk("lat4_req", 32'(s_req[2]), 1);
      chk("lat4_de", 32'(s_de[2]), 0);
      step_to(33);
      chk("lat1_req", 32'(s_req[1]), 1);
      chk("lat1_xy", {s_x[1], s_y[1]}, 0);
      chk("lat1_de", 32'(s_de[1]), 0);
      step_to(34);
      chk("lat1_de_on", 32'(s_de[1]), 1);
      chk("lat0_req", 32'(s_req[0]), 1);

      // Pattern enable mid-frame 1; takes effect at the frame-1 wrap edge (197).
      step_to(150);
      #2 pat_en = 1'b1;
      step_to(196);
      chk("pat_before_wrap", 32'(s_pa[1]), 0);
      step_to(197);
      chk("pat_after_wrap", 32'(s_pa[1]), 1);
      for (int k = 230; k < 238; k++) begin
         step_to(k);
         chk($sformatf("bar%0d", k - 230), 32'(s_rgb[1]), 32'(k - 230));
      end
      step_to(250);
      #2 pat_en = 1'b0;
      step_to(294);
      chk("pat_hold", 32'(s_pa[1]), 1);
      step_to(295);
      chk("pat_off", 32'(s_pa[1]), 0);

      // Counters sit at h=5, v=3 of frame 3 here; outputs show an active pixel.
      step_to(342);
      chk("pre_rst_de", 32'(s_de[1]), 1);
      #2 rst = 1'b1;
      run_id = 1;
      #1;
      chk("async_de", 32'(s_de[1]), 0);
      chk("async_req", 32'(s_req[1]), 0);
      chk("async_x", 32'(s_x[1]), 0);
      chk("async_rgb", 32'(s_rgb[1]), 0);
      repeat (3) tick();
      #2 rst = 1'b0;

      last_ls = 0; hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fs_n = 0; de_seen = 0;
      for (int i = 0; i < 32500; i++) begin
         tick();
         if (cyc == 2) chk("restart_fs", 32'(s_fs[1]), 1);
         if (d_fs) fs_n++;
         if (d_ls) begin
            if (last_ls == 0) chk("ls_first", 32'(cyc), 2);
            else              chk("ls_period", 32'(cyc - last_ls), 1040);
            last_ls = cyc;
         end
         if (d_hs) hs_cnt++;
         else if (hs_cnt > 0) begin
            chk("hs_width", 32'(hs_cnt), 120);
            hs_cnt = 0;
         end
         if (d_vs) vs_cnt++;
         else if (vs_cnt > 0) begin
            chk("vs_width", 32'(vs_cnt), 6240);
            vs_cnt = 0;
         end
         if (d_de) begin
            if (!de_seen) chk("de_first", 32'(cyc), 30346);
            de_seen = 1;
            de_cnt++;
         end else if (de_cnt > 0) begin
            chk("de_width", 32'(de_cnt), 800);
            de_cnt = 0;
         end
      end
      chk("de_seen", 32'(de_seen), 1);
      chk("fs_count", 32'(fs_n), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
